mvm_load_sequencer: RTL

Controller that sequences one matrix-vector multiply on the DE1-SoC minilab datapath. It sits between the Avalon-MM read-only memory wrapper and the `mat_vec_mult` MAC array. On `start` it clears the MAC array and fetches DEPTH matrix rows plus one vector line. It pushes the rows into the A FIFOs, streams the vector bytes into the B FIFO, waits for the MAC `done`, and holds a completion flag for the top-level display logic.

---
 rtl/mvm_pkg.sv | 33 +++
 rtl/mvm_load_sequencer_if.sv | 33 +++
 rtl/avalon_rd_port.sv | 76 +++++++
 rtl/mvm_load_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the MVM load sequencer: geometry defaults,
// FSM state encoding and the MSB-first line-to-lane unpack helper.
package mvm_pkg;

    localparam int unsigned MvmDataWidth = 8;
    localparam int unsigned MvmDepth     = 8;
    localparam int unsigned MvmLineWidth = MvmDataWidth * MvmDepth;

    // Plain vector constants keep the encoding compatible with older tools.
    typedef logic [3:0] mvm_seq_state_t;

    localparam mvm_seq_state_t StIdle    = 4'd0;
    localparam mvm_seq_state_t StClear   = 4'd1;
    localparam mvm_seq_state_t StReqA    = 4'd2;
    localparam mvm_seq_state_t StWaitA   = 4'd3;
    localparam mvm_seq_state_t StReqB    = 4'd4;
    localparam mvm_seq_state_t StWaitB   = 4'd5;
    localparam mvm_seq_state_t StStreamB = 4'd6;
    localparam mvm_seq_state_t StWaitMac = 4'd7;
    localparam mvm_seq_state_t StDone    = 4'd8;
    localparam mvm_seq_state_t StError   = 4'd9;

    // Lane 0 is the most significant element of the line.
    function automatic logic [MvmDataWidth-1:0] mvm_unpack_lane(
        input logic [MvmLineWidth-1:0] line,
        input int unsigned             lane
    );
        logic [MvmLineWidth-1:0] shifted;
        shifted = line << (lane * MvmDataWidth);
        return shifted[MvmLineWidth-1 -: MvmDataWidth];
    endfunction

endpackage

// File: rtl/mvm_load_sequencer_if.sv
// Memory-side (Avalon-MM read) and datapath-side (MAC array / FIFOs)
// signals of the MVM load sequencer. The sequencer is the master.
interface mvm_load_sequencer_if
    import mvm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MvmDataWidth,
    parameter int unsigned DEPTH      = MvmDepth
);

    logic [31:0]                 mem_address;
    logic                        mem_read;
    logic [63:0]                 mem_readdata;
    logic                        mem_readdatavalid;
    logic                        mem_waitrequest;

    logic                        mac_clr;
    logic                        a_wren;
    logic [DEPTH*DATA_WIDTH-1:0] a_data;
    logic                        b_wren;
    logic [DATA_WIDTH-1:0]       b_data;
    logic                        mac_done;

    modport master (
        output mem_address, mem_read, mac_clr, a_wren, a_data, b_wren, b_data,
        input  mem_readdata, mem_readdatavalid, mem_waitrequest, mac_done
    );

    modport slave (
        input  mem_address, mem_read, mac_clr, a_wren, a_data, b_wren, b_data,
        output mem_readdata, mem_readdatavalid, mem_waitrequest, mac_done
    );

endinterface

// File: rtl/avalon_rd_port.sv
// Single-outstanding Avalon-MM read handshake, shared by the row and vector
// fetches. A request raises mem_read one cycle later with a registered,
// stable address; acceptance drops it and opens the data window.
// Optional macro MVM_SEQ_TIMEOUT_EN adds a watchdog on the data window.
module avalon_rd_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] req_addr,
    output logic        accept,
    output logic        rd_valid,
    output logic        timeout,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid
);

    logic        read_q;
    logic        pend_q;
    logic [31:0] addr_q;

    assign accept      = read_q && !mem_waitrequest;
    assign rd_valid    = pend_q && mem_readdatavalid;
    assign mem_read    = read_q;
    assign mem_address = addr_q;

    // Issue one read per request, hold it until accepted, then track the data window.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            read_q <= 1'b0;
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            if (req && !read_q && !pend_q) begin
                read_q <= 1'b1;
                addr_q <= req_addr;
            end else if (accept) begin
                read_q <= 1'b0;
            end

            if (accept) begin
                pend_q <= 1'b1;
            end else if (rd_valid || timeout) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifdef MVM_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] wd_q;

    // Count data-window cycles; restart on every accepted read.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (accept) begin
            wd_q <= '0;
        end else if (pend_q && !mem_readdatavalid) begin
            wd_q <= wd_q + CntW'(1);
        end
    end

    assign timeout = pend_q && !mem_readdatavalid && (wd_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: rtl/mvm_load_sequencer.sv
// Sequences one matrix-vector multiply: clears the MAC array, fetches DEPTH
// row lines into the A FIFOs, fetches the vector line and streams it element
// by element into the B FIFO, then waits for the MAC array to finish.
// Optional macro MVM_SEQ_TIMEOUT_EN enables the read watchdog and ERROR state.
module mvm_load_sequencer
    import mvm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = MvmDataWidth,
    parameter int unsigned DEPTH          = MvmDepth,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 start,
    mvm_load_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned     IdxW    = $clog2(DEPTH) + 1;
    localparam int unsigned     LineW   = DEPTH * DATA_WIDTH;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

    mvm_seq_state_t  state_q, state_d;
    logic [IdxW-1:0] row_idx_q, row_idx_d;
    logic [IdxW-1:0] b_idx_q, b_idx_d;
    logic            a_wren_q;
    logic [LineW-1:0] a_data_q;
    logic [LineW-1:0] vec_q;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_accept;
    logic        rd_valid;
    logic        rd_timeout;
    logic [31:0] rd_mem_address;
    logic        rd_mem_read;

    assign rd_req  = (state_q == StReqA) || (state_q == StReqB);
    assign rd_addr = (state_q == StReqA) ? 32'(BASE_ADDR) + 32'(row_idx_q)
                                         : 32'(BASE_ADDR + DEPTH);

    avalon_rd_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd_port (
        .CLOCK_50         (CLOCK_50),
        .rst_n            (rst_n),
        .req              (rd_req),
        .req_addr         (rd_addr),
        .accept           (rd_accept),
        .rd_valid         (rd_valid),
        .timeout          (rd_timeout),
        .mem_address      (rd_mem_address),
        .mem_read         (rd_mem_read),
        .mem_waitrequest  (bus.mem_waitrequest),
        .mem_readdatavalid(bus.mem_readdatavalid)
    );

    // Next-state and index bookkeeping.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        b_idx_d   = b_idx_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                row_idx_d = '0;
                b_idx_d   = '0;
                state_d   = StReqA;
            end
            StReqA: begin
                if (rd_accept) state_d = StWaitA;
            end
            StWaitA: begin
                if (rd_valid) begin
                    row_idx_d = row_idx_q + IdxW'(1);
                    state_d   = (row_idx_q == LastIdx) ? StReqB : StReqA;
                end else if (rd_timeout) begin
                    state_d = StError;
                end
            end
            StReqB: begin
                if (rd_accept) state_d = StWaitB;
            end
            StWaitB: begin
                if (rd_valid) begin
                    b_idx_d = '0;
                    state_d = StStreamB;
                end else if (rd_timeout) begin
                    state_d = StError;
                end
            end
            StStreamB: begin
                b_idx_d = b_idx_q + IdxW'(1);
                if (b_idx_q == LastIdx) state_d = StWaitMac;
            end
            StWaitMac: begin
                if (bus.mac_done) state_d = StDone;
            end
            StDone, StError: begin
                if (start) state_d = StClear;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and indices.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_idx_q <= '0;
            b_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            b_idx_q   <= b_idx_d;
        end
    end

    // Latch returned lines; a row push fires the cycle after its data strobe.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            a_wren_q <= 1'b0;
            a_data_q <= '0;
            vec_q    <= '0;
        end else begin
            a_wren_q <= (state_q == StWaitA) && rd_valid;
            if ((state_q == StWaitA) && rd_valid) a_data_q <= bus.mem_readdata;
            if ((state_q == StWaitB) && rd_valid) vec_q <= bus.mem_readdata;
        end
    end

    assign bus.mem_address = rd_mem_address;
    assign bus.mem_read    = rd_mem_read;
    assign bus.mac_clr     = (state_q == StClear);
    assign bus.a_wren      = a_wren_q;
    assign bus.a_data      = a_data_q;
    assign bus.b_wren      = (state_q == StStreamB);
    assign bus.b_data      = (state_q == StStreamB) ? mvm_unpack_lane(vec_q, 32'(b_idx_q)) : '0;

    assign busy = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
    assign done = (state_q == StDone);

`ifdef MVM_SEQ_TIMEOUT_EN
    assign error = (state_q == StError);
`else
    assign error = 1'b0;
`endif

endmodule
